// File: rtl/rw_stage.sv
// Register-writeback stage: aligns/extends load data, picks each lane's writeback value, and
// registers the two register-file write ports. Optional retired counter under RW_INSTRET_EN.
module rw_stage #(
    parameter int unsigned XLEN = 32
`ifdef RW_INSTRET_EN
    ,
    parameter int unsigned CNT_W = 64
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            validMA1,
    input  logic            validMA2,
    input  logic [4:0]      dstregMA1,
    input  logic [4:0]      dstregMA2,
    input  logic            reg_weMA1,
    input  logic            reg_weMA2,
    input  logic            is_loadMA1,
    input  logic            is_loadMA2,
    input  logic [2:0]      funct3MA1,
    input  logic [2:0]      funct3MA2,
    input  logic [XLEN-1:0] alu_resultMA1,
    input  logic [XLEN-1:0] alu_resultMA2,
    input  logic [XLEN-1:0] load_dataMA1,
    input  logic [XLEN-1:0] load_dataMA2,
`ifdef RW_INSTRET_EN
    output logic [CNT_W-1:0] instret,
`endif
    output logic [4:0]      w_addrRW1,
    output logic [4:0]      w_addrRW2,
    output logic [XLEN-1:0] wb_dataRW1,
    output logic [XLEN-1:0] wb_dataRW2,
    output logic            wb_enRW1,
    output logic            wb_enRW2
);

    localparam int unsigned BW = 8;
    localparam int unsigned HW = 16;

    // Only LB/LH/LW/LBU/LHU are legal load encodings.
    function automatic logic load_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d,
                                                input logic [2:0] f3,
                                                input logic [1:0] a);
        logic [BW-1:0] b;
        logic [HW-1:0] h;
        logic [XLEN-1:0] r;
        b = d[BW*a +: BW];
        h = a[1] ? d[HW +: HW] : d[0 +: HW];
        case (f3)
            3'b000:  r = {{(XLEN-BW){b[BW-1]}}, b};
            3'b100:  r = {{(XLEN-BW){1'b0}}, b};
            3'b001:  r = {{(XLEN-HW){h[HW-1]}}, h};
            3'b101:  r = {{(XLEN-HW){1'b0}}, h};
            3'b010:  r = d;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] lane_data(input logic v, input logic ld,
                                                  input logic [2:0] f3,
                                                  input logic [XLEN-1:0] alu,
                                                  input logic [XLEN-1:0] d);
        if (!v)
            return '0;
        else if (ld)
            return extract(d, f3, alu[1:0]);
        else
            return alu;
    endfunction

    logic            en1, en2, coll;
    logic            wen1_c, wen2_c;
    logic [XLEN-1:0] data1_c, data2_c;

    // Lane enables; on a same-destination collision the younger lane 2 wins.
    always_comb begin
        en1     = validMA1 & reg_weMA1 & (dstregMA1 != 5'd0);
        en2     = validMA2 & reg_weMA2 & (dstregMA2 != 5'd0);
        coll    = en1 & en2 & (dstregMA1 == dstregMA2);
        wen1_c  = en1 & ~coll & ~(is_loadMA1 & ~load_ok(funct3MA1));
        wen2_c  = en2 & ~(is_loadMA2 & ~load_ok(funct3MA2));
        data1_c = lane_data(validMA1, is_loadMA1, funct3MA1, alu_resultMA1, load_dataMA1);
        data2_c = lane_data(validMA2, is_loadMA2, funct3MA2, alu_resultMA2, load_dataMA2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addrRW1  <= 5'd0;
            w_addrRW2  <= 5'd0;
            wb_dataRW1 <= '0;
            wb_dataRW2 <= '0;
            wb_enRW1   <= 1'b0;
            wb_enRW2   <= 1'b0;
        end else begin
            w_addrRW1  <= dstregMA1;
            w_addrRW2  <= dstregMA2;
            wb_dataRW1 <= data1_c;
            wb_dataRW2 <= data2_c;
            wb_enRW1   <= wen1_c;
            wb_enRW2   <= wen2_c;
        end
    end

`ifdef RW_INSTRET_EN
    // Counts every valid slot, including stores, branches and rd=x0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instret <= '0;
        else
            instret <= instret + CNT_W'({1'b0, validMA1} + {1'b0, validMA2});
    end
`endif

endmodule

// File: tb/tb_rw_stage.sv
// Scoreboard bench for rw_stage: directed vectors push expected writes, a monitor pops and checks.
module tb_rw_stage;

    typedef struct packed {
        logic        v;
        logic [4:0]  dst;
        logic        we;
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] ldd;
    } lane_t;

    typedef struct packed {
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        e1;
        logic [4:0]  a2;
        logic [31:0] d2;
        logic        e2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        validMA1, validMA2, reg_weMA1, reg_weMA2, is_loadMA1, is_loadMA2;
    logic [4:0]  dstregMA1, dstregMA2;
    logic [2:0]  funct3MA1, funct3MA2;
    logic [31:0] alu_resultMA1, alu_resultMA2, load_dataMA1, load_dataMA2;
    logic [4:0]  w_addrRW1, w_addrRW2;
    logic [31:0] wb_dataRW1, wb_dataRW2;
    logic        wb_enRW1, wb_enRW2;
`ifdef RW_INSTRET_EN
    logic [63:0] instret;
`endif

    int total = 0;
    int bad = 0;
    exp_t q[$];

    rw_stage dut (
        .clk(clk), .rst(rst),
        .validMA1(validMA1), .validMA2(validMA2),
        .dstregMA1(dstregMA1), .dstregMA2(dstregMA2),
        .reg_weMA1(reg_weMA1), .reg_weMA2(reg_weMA2),
        .is_loadMA1(is_loadMA1), .is_loadMA2(is_loadMA2),
        .funct3MA1(funct3MA1), .funct3MA2(funct3MA2),
        .alu_resultMA1(alu_resultMA1), .alu_resultMA2(alu_resultMA2),
        .load_dataMA1(load_dataMA1), .load_dataMA2(load_dataMA2),
`ifdef RW_INSTRET_EN
        .instret(instret),
`endif
        .w_addrRW1(w_addrRW1), .w_addrRW2(w_addrRW2),
        .wb_dataRW1(wb_dataRW1), .wb_dataRW2(wb_dataRW2),
        .wb_enRW1(wb_enRW1), .wb_enRW2(wb_enRW2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic lane_t ln(input logic v, input logic [4:0] dst, input logic we,
                                 input logic ld, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] ldd);
        lane_t l;
        l.v = v; l.dst = dst; l.we = we; l.ld = ld; l.f3 = f3; l.alu = alu; l.ldd = ldd;
        return l;
    endfunction

    function automatic exp_t ex(input logic [4:0] a1, input logic [31:0] d1, input logic e1,
                                input logic [4:0] a2, input logic [31:0] d2, input logic e2);
        exp_t e;
        e.a1 = a1; e.d1 = d1; e.e1 = e1; e.a2 = a2; e.d2 = d2; e.e2 = e2;
        return e;
    endfunction

    task automatic apply(input lane_t a, input lane_t b);
        validMA1 = a.v; dstregMA1 = a.dst; reg_weMA1 = a.we; is_loadMA1 = a.ld;
        funct3MA1 = a.f3; alu_resultMA1 = a.alu; load_dataMA1 = a.ldd;
        validMA2 = b.v; dstregMA2 = b.dst; reg_weMA2 = b.we; is_loadMA2 = b.ld;
        funct3MA2 = b.f3; alu_resultMA2 = b.alu; load_dataMA2 = b.ldd;
    endtask

    task automatic drive(input lane_t a, input lane_t b, input exp_t e);
        @(negedge clk);
        apply(a, b);
        q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        check({name, ".a1"}, 64'(w_addrRW1), 64'd0);
        check({name, ".d1"}, 64'(wb_dataRW1), 64'd0);
        check({name, ".e1"}, 64'(wb_enRW1), 64'd0);
        check({name, ".a2"}, 64'(w_addrRW2), 64'd0);
        check({name, ".d2"}, 64'(wb_dataRW2), 64'd0);
        check({name, ".e2"}, 64'(wb_enRW2), 64'd0);
    endtask

    // Monitor: every registered output pair after a driven cycle is compared to the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("w_addrRW1", 64'(w_addrRW1), 64'(e.a1));
                check("wb_dataRW1", 64'(wb_dataRW1), 64'(e.d1));
                check("wb_enRW1", 64'(wb_enRW1), 64'(e.e1));
                check("w_addrRW2", 64'(w_addrRW2), 64'(e.a2));
                check("wb_dataRW2", 64'(wb_dataRW2), 64'(e.d2));
                check("wb_enRW2", 64'(wb_enRW2), 64'(e.e2));
            end
        end
    end

    localparam logic [31:0] BYTES = 32'h80FF7F01;
    localparam logic [31:0] HALFS = 32'h8001FFFE;

    initial begin
        lane_t idle;
        idle = '0;
        apply(idle, idle);

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply(ln(1'b1, 5'($urandom), 1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom),
                  ln(1'b1, 5'($urandom), 1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom));
            @(posedge clk);
            #1;
            check_zero("reset_hold");
        end

        // Release straight into a write
        @(negedge clk);
        rst = 1'b0;
        apply(ln(1'b1, 5'd5, 1'b1, 1'b0, 3'd0, 32'h1234, 32'h0), idle);
        q.push_back(ex(5'd5, 32'h1234, 1'b1, 5'd0, 32'h0, 1'b0));

        // Byte loads
        drive(ln(1, 5'd1, 1, 1, 3'b000, 32'h0, BYTES), ln(1, 5'd2, 1, 1, 3'b000, 32'h1, BYTES),
              ex(5'd1, 32'h00000001, 1, 5'd2, 32'h0000007F, 1));
        drive(ln(1, 5'd3, 1, 1, 3'b000, 32'h2, BYTES), ln(1, 5'd4, 1, 1, 3'b000, 32'h3, BYTES),
              ex(5'd3, 32'hFFFFFFFF, 1, 5'd4, 32'hFFFFFF80, 1));
        drive(ln(1, 5'd5, 1, 1, 3'b100, 32'h3, BYTES), ln(1, 5'd6, 1, 1, 3'b001, 32'h1002, HALFS),
              ex(5'd5, 32'h00000080, 1, 5'd6, 32'hFFFF8001, 1));
        // Halfword / word loads, a[0] ignored for LH
        drive(ln(1, 5'd7, 1, 1, 3'b101, 32'h2000, HALFS), ln(1, 5'd8, 1, 1, 3'b010, 32'h3, HALFS),
              ex(5'd7, 32'h0000FFFE, 1, 5'd8, 32'h8001FFFE, 1));
        drive(ln(1, 5'd9, 1, 1, 3'b001, 32'h3, HALFS), ln(1, 5'd10, 1, 1, 3'b101, 32'h2, HALFS),
              ex(5'd9, 32'hFFFF8001, 1, 5'd10, 32'h00008001, 1));
        // Illegal funct3 codes
        drive(ln(1, 5'd6, 1, 1, 3'b011, 32'h0, HALFS), ln(1, 5'd7, 1, 1, 3'b110, 32'h0, HALFS),
              ex(5'd6, 32'h0, 0, 5'd7, 32'h0, 0));
        drive(ln(1, 5'd11, 1, 1, 3'b111, 32'h0, HALFS), ln(1, 5'd12, 1, 0, 3'b011, 32'h55, HALFS),
              ex(5'd11, 32'h0, 0, 5'd12, 32'h55, 1));

        // Collisions
        drive(ln(1, 5'd7, 1, 0, 3'd0, 32'h11, 32'h0), ln(1, 5'd7, 1, 0, 3'd0, 32'h22, 32'h0),
              ex(5'd7, 32'h11, 0, 5'd7, 32'h22, 1));
        drive(ln(1, 5'd0, 1, 0, 3'd0, 32'h33, 32'h0), ln(1, 5'd0, 1, 0, 3'd0, 32'h44, 32'h0),
              ex(5'd0, 32'h33, 0, 5'd0, 32'h44, 0));
        drive(ln(1, 5'd9, 0, 0, 3'd0, 32'h5, 32'h0), ln(1, 5'd9, 1, 0, 3'd0, 32'h66, 32'h0),
              ex(5'd9, 32'h5, 0, 5'd9, 32'h66, 1));
        drive(ln(1, 5'd13, 1, 0, 3'd0, 32'hA1, 32'h0), ln(1, 5'd14, 1, 0, 3'd0, 32'hB2, 32'h0),
              ex(5'd13, 32'hA1, 1, 5'd14, 32'hB2, 1));

        // Bubbles
        drive(ln(0, 5'd8, 1, 0, 3'd0, 32'hDEAD, 32'h0), ln(1, 5'd3, 1, 0, 3'd0, 32'hCAFE, 32'h0),
              ex(5'd8, 32'h0, 0, 5'd3, 32'hCAFE, 1));
        drive(ln(1, 5'd4, 1, 1, 3'b000, 32'h1, BYTES), ln(0, 5'd2, 1, 1, 3'b010, 32'h0, BYTES),
              ex(5'd4, 32'h0000007F, 1, 5'd2, 32'h0, 0));

        // Reset while a write is on the outputs
        drive(ln(1, 5'd10, 1, 0, 3'd0, 32'hAAAA5555, 32'h0), idle,
              ex(5'd10, 32'hAAAA5555, 1, 5'd0, 32'h0, 0));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        apply(ln(1, 5'd15, 1, 0, 3'd0, 32'h77, 32'h0), ln(1, 5'd16, 1, 0, 3'd0, 32'h88, 32'h0));
        @(negedge clk);
        rst = 1'b0;
        apply(idle, idle);
        q.push_back(ex(5'd0, 32'h0, 0, 5'd0, 32'h0, 0));

`ifdef RW_INSTRET_EN
        // Counter: 10 dual-valid plus 3 single-valid slots
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply(idle, idle);
        for (int i = 0; i < 10; i++)
            drive(ln(1, 5'd0, 0, 0, 3'd0, 32'h0, 32'h0), ln(1, 5'd0, 0, 0, 3'd0, 32'h0, 32'h0),
                  ex(5'd0, 32'h0, 0, 5'd0, 32'h0, 0));
        for (int i = 0; i < 3; i++)
            drive(ln(1, 5'd0, 0, 0, 3'd0, 32'h0, 32'h0), idle,
                  ex(5'd0, 32'h0, 0, 5'd0, 32'h0, 0));
        @(posedge clk);
        #2;
        check("instret_23", instret, 64'd23);
        @(negedge clk);
        force dut.instret = '1;
        apply(ln(1, 5'd0, 0, 0, 3'd0, 32'h0, 32'h0), ln(1, 5'd0, 0, 0, 3'd0, 32'h0, 32'h0));
        q.push_back(ex(5'd0, 32'h0, 0, 5'd0, 32'h0, 0));
        #1;
        release dut.instret;
        @(posedge clk);
        #2;
        check("instret_wrap", instret, 64'd1);
        @(negedge clk);
        apply(idle, idle);
`endif

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        check("scoreboard_drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rw_stage.md
Name: rw_stage

Overview:
- Register-writeback stage of the 2-wide in-order pipeline, one cycle after memory access.
- Takes both lanes from MA, aligns and extends load data, and chooses each lane's writeback value (ALU result or load data).
- Registers the results and drives the register-file write ports consumed by RR: w_addrRW1/2, wb_dataRW1/2, wb_enRW1/2.
- Optionally keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter (used only with RW_INSTRET_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- validMA1, validMA2  in  1  lane holds a real instruction (not a bubble or flushed slot).
- dstregMA1, dstregMA2  in  5  destination register.
- reg_weMA1, reg_weMA2  in  1  instruction writes a register.
- is_loadMA1, is_loadMA2  in  1  instruction is a load.
- funct3MA1, funct3MA2  in  3  load size/sign code.
- alu_resultMA1, alu_resultMA2  in  32  ALU result; for loads this is the effective address.
- load_dataMA1, load_dataMA2  in  32  raw aligned word from data memory.
- w_addrRW1, w_addrRW2  out  5  write address to the register file.
- wb_dataRW1, wb_dataRW2  out  32  write data.
- wb_enRW1, wb_enRW2  out  1  write enable.
- instret  out  CNT_W  retired count (present only with RW_INSTRET_EN).

Behaviour:
- Reset (rst=1, asynchronous):
  - w_addrRW1/2 = 0, wb_dataRW1/2 = 0, wb_enRW1/2 = 0, instret = 0.
  - Releasing reset produces no spurious write.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and are held for one cycle. There is no stall; each cycle is a new pair.
- Per-lane enable, before registering:
  - en_i = validMA_i & reg_weMA_i & (dstregMA_i != 0).
  - w_addrRW_i = dstregMA_i, registered regardless of en_i.
- Same-destination collision:
  - If en_1 and en_2 are both set and dstregMA1 == dstregMA2, lane 2 (the younger instruction) wins.
  - wb_enRW1 = 0, wb_enRW2 = 1; both data values are still registered.
- Writeback data selection:
  - Non-load: wb_data = alu_result.
  - Load: wb_data = extract(load_data, funct3, a), where a = alu_result[1:0].
- Load extraction:
  - 000 LB: byte at bits [8a+7:8a], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at bits [16*a[1]+15:16*a[1]], sign-extended; a[0] is ignored (misalignment is caught upstream).
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word; a is ignored.
  - 011, 110, 111: data = 0 and wb_en for that lane is forced to 0.
- When validMA_i = 0: wb_data_i = 0 and wb_en_i = 0. Lane 2 valid with lane 1 invalid is legal.
- Reset asserted mid-operation: outputs clear at once (asynchronously). The pair in flight is dropped and never written.
- Purely combinational paths from inputs to outputs are prohibited; all outputs come from flops.

Optional Feature:
- Macro RW_INSTRET_EN.
- Defined:
  - Port instret exists.
  - Each edge, instret += validMA1 + validMA2 (0, 1 or 2), counting stores, branches and rd=x0 instructions.
  - Wraps modulo 2^CNT_W; all-ones + 2 = 1.
  - Resets to 0; updated in the same cycle as the outputs.
- Undefined: no instret port and no counter flops; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 with random inputs -> all outputs 0. Release with validMA1=1, reg_weMA1=1, dstregMA1=5, alu_resultMA1=0x1234 -> next cycle w_addrRW1=5, wb_dataRW1=0x1234, wb_enRW1=1.
- Byte loads: load_data=0x80FF7F01, LB at a=0/1/2/3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. LBU at a=3 -> 0x00000080.
- Halfword/word loads: load_data=0x8001FFFE, LH a=2 -> 0xFFFF8001; LHU a=0 -> 0x0000FFFE; LW -> 0x8001FFFE. funct3=011 -> wb_en=0, data 0.
- Collision: both lanes valid, dst=7, data 0x11 and 0x22 -> wb_enRW1=0, wb_enRW2=1, wb_dataRW2=0x22. Repeat with dst=0 on both -> both enables 0.
- Bubbles: validMA1=0, validMA2=1, dst=3 -> wb_enRW1=0, wb_enRW2=1. Assert rst while the outputs show a write -> wb_en drops immediately, before the next edge.
- RW_INSTRET_EN: 10 cycles of dual-valid then 3 cycles of single-valid -> instret=23. Preload near wrap (force 2^64-1) plus a dual-valid cycle -> 1.
